// File: rtl/blink_rate_meter.sv
// ============================================================================
//  Module      : blink_rate_meter
//  Description : Measures the rising-edge period of an external blink signal
//                and classifies it as the 1 s or the 0.5 s blink rate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_rate_meter #(
    parameter int unsigned NOM_SLOW   = 50000002,
    parameter int unsigned NOM_FAST   = 25000002,
    parameter int unsigned TOL        = 500000,
    parameter int unsigned MIN_PERIOD = 1000,
    parameter int unsigned TIMEOUT    = 100000000
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        sig_in,
    output logic [26:0] period,
    output logic        period_valid,
    output logic        is_slow,
    output logic        is_fast,
    output logic        timeout,
    output logic        glitch
);

    localparam logic [27:0] c_NOM_SLOW   = 28'(NOM_SLOW);
    localparam logic [27:0] c_NOM_FAST   = 28'(NOM_FAST);
    localparam logic [27:0] c_TOL        = 28'(TOL);
    localparam logic [26:0] c_MIN_PERIOD = 27'(MIN_PERIOD);
    localparam logic [26:0] c_TIMEOUT    = 27'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_s1;
    logic        r_s2;
    logic        r_sd;
    logic [26:0] r_cnt;

    logic        w_rise;
    logic [27:0] w_cnt_ext;
    logic [27:0] w_diff_slow;
    logic [27:0] w_diff_fast;
    logic        w_in_slow;
    logic        w_in_fast;

    assign w_rise    = r_s2 & ~r_sd;
    assign w_cnt_ext = {1'b0, r_cnt};

    // Absolute distance from each nominal period, one bit wider than the counter
    assign w_diff_slow = (w_cnt_ext >= c_NOM_SLOW) ? (w_cnt_ext - c_NOM_SLOW)
                                                   : (c_NOM_SLOW - w_cnt_ext);
    assign w_diff_fast = (w_cnt_ext >= c_NOM_FAST) ? (w_cnt_ext - c_NOM_FAST)
                                                   : (c_NOM_FAST - w_cnt_ext);
    assign w_in_slow   = (w_diff_slow <= c_TOL);
    assign w_in_fast   = (w_diff_fast <= c_TOL);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_sd         <= 1'b0;
            r_cnt        <= 27'd0;
            period       <= 27'd0;
            period_valid <= 1'b0;
            is_slow      <= 1'b0;
            is_fast      <= 1'b0;
            timeout      <= 1'b0;
            glitch       <= 1'b0;
        end else begin
            r_s1         <= sig_in;
            r_s2         <= r_s1;
            r_sd         <= r_s2;
            period_valid <= 1'b0;
            glitch       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 27'd0;
                    // First edge only establishes the reference
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= 27'd1;
                        timeout <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        if (r_cnt >= c_MIN_PERIOD) begin
                            period       <= r_cnt;
                            period_valid <= 1'b1;
                            is_slow      <= w_in_slow;
                            is_fast      <= w_in_fast;
                            r_cnt        <= 27'd1;
                        end else begin
                            // Early edge: keep the old reference and keep counting
                            glitch <= 1'b1;
                            r_cnt  <= r_cnt + 27'd1;
                        end
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 27'd0;
                        timeout <= 1'b1;
                        is_slow <= 1'b0;
                        is_fast <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 27'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 27'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_blink_rate_meter.sv
// ============================================================================
//  Module      : tb_blink_rate_meter
//  Description : Self-checking bench for blink_rate_meter with an edge-time
//                reference model, directed scenarios and randomized waves.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blink_rate_meter;

    localparam int c_NOM_SLOW   = 200;
    localparam int c_NOM_FAST   = 100;
    localparam int c_TOL        = 5;
    localparam int c_MIN_PERIOD = 10;
    localparam int c_TIMEOUT    = 400;

    logic        clk_50M;
    logic        rst;
    logic        sig_in;
    logic [26:0] period;
    logic        period_valid;
    logic        is_slow;
    logic        is_fast;
    logic        timeout;
    logic        glitch;

    blink_rate_meter #(
        .NOM_SLOW   (c_NOM_SLOW),
        .NOM_FAST   (c_NOM_FAST),
        .TOL        (c_TOL),
        .MIN_PERIOD (c_MIN_PERIOD),
        .TIMEOUT    (c_TIMEOUT)
    ) u_dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .is_slow      (is_slow),
        .is_fast      (is_fast),
        .timeout      (timeout),
        .glitch       (glitch)
    );

    initial begin
        clk_50M = 1'b0;
        forever #5 clk_50M = ~clk_50M;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: works on absolute edge numbers of accepted rising edges
    int          cyc = 0;
    bit          m_prev = 0;
    int          m_pend[$];
    bit          m_active = 0;
    int          m_ref = 0;
    logic [26:0] e_period = '0;
    logic        e_pv = 0, e_slow = 0, e_fast = 0, e_to = 0, e_gl = 0;

    task automatic model_step();
        bit rise_now;
        int d;
        cyc++;
        if (rst) begin
            e_period = '0; e_pv = 0; e_slow = 0; e_fast = 0; e_to = 0; e_gl = 0;
            m_prev = 0; m_active = 0;
            m_pend.delete();
        end else begin
            e_pv = 0;
            e_gl = 0;
            rise_now = 0;
            if (m_pend.size() > 0 && m_pend[0] == cyc) begin
                rise_now = 1;
                void'(m_pend.pop_front());
            end
            if (!m_active) begin
                if (rise_now) begin
                    m_active = 1;
                    m_ref    = cyc;
                    e_to     = 0;
                end
            end else begin
                d = cyc - m_ref;
                if (rise_now && d >= c_MIN_PERIOD) begin
                    e_period = 27'(d);
                    e_pv     = 1;
                    e_slow   = (d >= c_NOM_SLOW - c_TOL) && (d <= c_NOM_SLOW + c_TOL);
                    e_fast   = (d >= c_NOM_FAST - c_TOL) && (d <= c_NOM_FAST + c_TOL);
                    m_ref    = cyc;
                end else if (rise_now) begin
                    e_gl = 1;
                end else if (d == c_TIMEOUT) begin
                    m_active = 0;
                    e_to     = 1;
                    e_slow   = 0;
                    e_fast   = 0;
                end
            end
            // A sampled 0->1 acts on the registered outputs two edges later
            if (sig_in && !m_prev) m_pend.push_back(cyc + 2);
            m_prev = sig_in;
        end
    endtask

    logic [26:0] cap_period = '0;
    logic        cap_slow = 0, cap_fast = 0;
    int          n_pv = 0, n_gl = 0;

    task automatic tick();
        @(posedge clk_50M);
        model_step();
        @(negedge clk_50M);
        check_value("outs", {period, period_valid, is_slow, is_fast, timeout, glitch},
                    {e_period, e_pv, e_slow, e_fast, e_to, e_gl});
        if (period_valid) begin
            cap_period = period;
            cap_slow   = is_slow;
            cap_fast   = is_fast;
            n_pv++;
        end
        if (glitch) n_gl++;
    endtask

    task automatic pulse(input int hi, input int lo);
        sig_in = 1'b1;
        repeat (hi) tick();
        sig_in = 1'b0;
        repeat (lo) tick();
    endtask

    int p_list[7] = '{100, 100, 105, 106, 95, 94, 100};
    bit f_list[7] = '{1, 1, 1, 0, 1, 0, 1};
    int pv0, gl0, p, hi, mode;

    initial begin
        if (c_NOM_FAST + c_TOL >= c_NOM_SLOW - c_TOL) begin
            $display("FAIL params: classification windows overlap");
            $fatal(1);
        end
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) tick();
        check_value("reset_outs", {period, period_valid, is_slow, is_fast, timeout, glitch}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Slow wave: first rise only arms the measurement
        pulse(100, 100);
        check_value("slow_no_first_pv", n_pv, 0);
        pulse(100, 100);
        check_value("slow_pv_count", n_pv, 1);
        check_value("slow_period", cap_period, 200);
        check_value("slow_is_slow", cap_slow, 1);
        check_value("slow_is_fast", cap_fast, 0);
        check_value("slow_timeout", timeout, 0);
        pulse(100, 100);

        // Fast wave and window boundaries
        for (int i = 0; i < 7; i++) begin
            pulse(50, p_list[i] - 50);
            if (i >= 1) begin
                check_value("fast_period", cap_period, p_list[i-1]);
                check_value("fast_is_fast", cap_fast, f_list[i-1]);
            end
        end

        // Glitch rejection
        pulse(100, 100);
        sig_in = 1'b1;
        repeat (3) tick();
        pv0 = n_pv;
        gl0 = n_gl;
        sig_in = 1'b0; repeat (2) tick();
        sig_in = 1'b1; repeat (2) tick();
        sig_in = 1'b0; repeat (193) tick();
        check_value("glitch_count", n_gl - gl0, 1);
        check_value("glitch_no_pv", n_pv - pv0, 0);
        pulse(100, 100);
        check_value("glitch_next_period", cap_period, 200);

        // Timeout
        sig_in = 1'b0;
        repeat (450) tick();
        check_value("to_flag", timeout, 1);
        check_value("to_class", {is_slow, is_fast}, 0);
        check_value("to_period_held", period, 200);
        pv0 = n_pv;
        pulse(100, 100);
        check_value("to_cleared", timeout, 0);
        check_value("to_rearm_no_pv", n_pv - pv0, 0);
        pulse(100, 100);
        check_value("to_resume_pv", n_pv - pv0, 1);
        check_value("to_resume_period", cap_period, 200);

        // Edge coinciding with cnt == TIMEOUT
        pulse(100, 300);
        pulse(100, 100);
        check_value("edge_to_period", cap_period, 400);
        check_value("edge_to_class", {cap_slow, cap_fast}, 0);
        check_value("edge_to_timeout", timeout, 0);

        // Reset mid-measurement
        pulse(100, 100);
        sig_in = 1'b1; repeat (100) tick();
        sig_in = 1'b0; repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("midrst_outs", {period, period_valid, is_slow, is_fast, timeout, glitch}, 32'd0);
        repeat (49) tick();
        pv0 = n_pv;
        repeat (3) pulse(100, 100);
        check_value("midrst_pv_count", n_pv - pv0, 2);
        check_value("midrst_period", cap_period, 200);

        // Randomized waves checked cycle by cycle against the model
        for (int i = 0; i < 80; i++) begin
            mode = int'($urandom_range(0, 9));
            if (mode < 4)       p = int'($urandom_range(c_NOM_FAST - 8, c_NOM_FAST + 8));
            else if (mode < 7)  p = int'($urandom_range(c_NOM_SLOW - 8, c_NOM_SLOW + 8));
            else if (mode == 7) p = int'($urandom_range(2, 15));
            else if (mode == 8) p = int'($urandom_range(c_TIMEOUT - 20, c_TIMEOUT + 20));
            else                p = 0;
            if (p == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                hi = int'($urandom_range(1, p - 1));
                pulse(hi, p - hi);
            end
        end
        sig_in = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
